// File: rtl/hex_text_writer_if.sv
// Print request channel between the debug/status logic and hex_text_writer.
// The requester drives the value/address/blanking request; the writer
// reports busy and a one-cycle done pulse back.
interface hex_text_writer_if #(
    parameter int DIGITS = 8,
    parameter int ADDR_W = 11
);
    logic                  req;
    logic [4*DIGITS-1:0]   value;
    logic [ADDR_W-1:0]     addr;
    logic                  blank;
    logic                  busy;
    logic                  done;

    modport master (output req, value, addr, blank, input  busy, done);
    modport slave  (input  req, value, addr, blank, output busy, done);
endinterface

// File: rtl/hex_text_writer.sv
// Prints a multi-digit hex value into the OSD text RAM, MSB digit first.
// Each digit goes through an external nibble-to-text converter with one
// registered cycle of latency, so the RAM write for digit idx is issued
// one cycle after its nibble is presented. Leading zeros can be replaced
// with SPACE_CHAR; blanked positions are still written so stale text is cleared.
module hex_text_writer #(
    parameter int          DIGITS     = 8,
    parameter int          ADDR_W     = 11,
    parameter logic [7:0]  SPACE_CHAR = 8'd0
) (
    input  logic               clk,
    input  logic               reset_n,
    hex_text_writer_if.slave   host,
    output logic [3:0]         nib,
    input  logic [7:0]         text,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [7:0]         wr_data
);
    localparam int                IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0]  LAST  = IDX_W'(DIGITS - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t               state, next_state;
    logic [IDX_W-1:0]     idx;
    logic [4*DIGITS-1:0]  digits;     // latched value, shifted left one digit per RUN cycle
    logic [ADDR_W-1:0]    base;
    logic                 blank_l;
    logic                 zero_run;   // every digit before idx was zero
    logic                 blank_d;    // write token: current write is a blanked digit
    logic [3:0]           cur_digit;
    logic                 last;
    logic                 blank_now;

    assign cur_digit = digits[4*DIGITS-1 -: 4];
    assign last      = (idx == LAST);
    assign blank_now = blank_l && zero_run && (cur_digit == 4'd0) && !last;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    // Next-state decode and status/converter outputs
    always_comb begin
        next_state = state;
        host.busy  = 1'b0;
        host.done  = 1'b0;
        nib        = 4'd0;
        case (state)
            IDLE:  if (host.req) next_state = RUN;
            RUN: begin
                host.busy = 1'b1;
                nib       = cur_digit;
                if (last) next_state = FLUSH;
            end
            FLUSH: begin
                host.busy  = 1'b1;
                next_state = DONE;
            end
            DONE: begin
                host.done  = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Request latches and digit stepping
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            digits   <= '0;
            base     <= '0;
            blank_l  <= 1'b0;
            idx      <= '0;
            zero_run <= 1'b0;
        end else begin
            case (state)
                IDLE: if (host.req) begin
                    digits   <= host.value;
                    base     <= host.addr;
                    blank_l  <= host.blank;
                    idx      <= '0;
                    zero_run <= 1'b1;
                end
                RUN: begin
                    digits   <= digits << 4;
                    idx      <= idx + 1'b1;
                    zero_run <= zero_run && (cur_digit == 4'd0);
                end
                default: ;
            endcase
        end
    end

    // Write token, aligned with the converter's one-cycle latency
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            blank_d <= 1'b0;
        end else begin
            wr_en <= (state == RUN);
            if (state == RUN) begin
                wr_addr <= base + ADDR_W'(idx);
                blank_d <= blank_now;
            end
        end
    end

    assign wr_data = blank_d ? SPACE_CHAR : text;
endmodule

// File: tb/tb_hex_text_writer.sv
// Bench for hex_text_writer: models the nibble_to_hex_text converter,
// captures every RAM write into a queue and compares against expected writes.
module tb_hex_text_writer;
    localparam logic [7:0] SPACE = 8'd0;

    typedef struct {
        logic [10:0] a;
        logic [7:0]  d;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  nib;
    logic [7:0]  text = 8'd0;
    logic        wr_en;
    logic [10:0] wr_addr;
    logic [7:0]  wr_data;

    int n_checks = 0;
    int n_pass   = 0;
    wr_t exp_q[$];
    wr_t obs_q[$];

    hex_text_writer_if #(.DIGITS(8), .ADDR_W(11)) hif ();

    hex_text_writer #(.DIGITS(8), .ADDR_W(11), .SPACE_CHAR(SPACE)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .host    (hif),
        .nib     (nib),
        .text    (text),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] hexc(input logic [3:0] n);
        return (n < 4'd10) ? 8'(16 + n) : 8'(23 + n);
    endfunction

    // Converter model: one registered cycle of latency
    always @(posedge clk) text <= hexc(nib);

    // Capture RAM writes away from the active edge
    always @(negedge clk) if (wr_en === 1'b1) obs_q.push_back('{wr_addr, wr_data});

    task automatic push_expected(input logic [31:0] v, input logic [10:0] a, input logic b);
        logic z;
        logic [3:0] d;
        z = 1'b1;
        for (int i = 0; i < 8; i++) begin
            d = v[31-4*i -: 4];
            z = z && (d == 4'd0);
            exp_q.push_back('{a + 11'(i), (b && z && i != 7) ? SPACE : hexc(d)});
        end
    endtask

    task automatic start(input logic [31:0] v, input logic [10:0] a, input logic b, input bit hold);
        @(negedge clk);
        hif.value = v;
        hif.addr  = a;
        hif.blank = b;
        hif.req   = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) hif.req = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        hif.req = 1'b0; hif.value = '0; hif.addr = '0; hif.blank = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (hif.busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", hif.busy); else n_pass++;
        n_checks++; if (hif.done !== 1'b0) $display("FAIL rst_done: got %b want 0", hif.done); else n_pass++;
        n_checks++; if (wr_en !== 1'b0) $display("FAIL rst_wr_en: got %b want 0", wr_en); else n_pass++;
        n_checks++; if (nib !== 4'd0) $display("FAIL rst_nib: got %h want 0", nib); else n_pass++;
        n_checks++; if (wr_addr !== 11'd0) $display("FAIL rst_wr_addr: got %h want 0", wr_addr); else n_pass++;
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        obs_q.delete();
        push_expected(32'hDEADBEEF, 11'h100, 1'b0);
        start(32'hDEADBEEF, 11'h100, 1'b0, 1'b0);
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            n_checks++;
            if (hif.busy !== 1'(c <= 9)) $display("FAIL basic_busy c%0d: got %b want %b", c, hif.busy, 1'(c <= 9));
            else n_pass++;
            n_checks++;
            if (hif.done !== 1'(c == 10)) $display("FAIL basic_done c%0d: got %b want %b", c, hif.done, 1'(c == 10));
            else n_pass++;
            if (c == 1) begin
                n_checks++; if (nib !== 4'hD) $display("FAIL basic_nib0: got %h want d", nib); else n_pass++;
            end
            if (c == 10) begin
                n_checks++; if (nib !== 4'h0) $display("FAIL basic_nib_idle: got %h want 0", nib); else n_pass++;
            end
        end
        n_checks++;
        if (obs_q.size() != exp_q.size()) $display("FAIL basic_count: got %0d want %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            wr_t e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++;
            if (o.a !== e.a || o.d !== e.d) $display("FAIL basic_wr: got %h:%0d want %h:%0d", o.a, o.d, e.a, e.d);
            else n_pass++;
        end
        exp_q.delete();
    endtask

    task automatic test_print(input string name, input logic [31:0] v, input logic [10:0] a, input logic b);
        obs_q.delete();
        push_expected(v, a, b);
        start(v, a, b, 1'b0);
        for (int i = 0; i < 40 && hif.done !== 1'b1; i++) @(negedge clk);
        n_checks++; if (hif.done !== 1'b1) $display("FAIL %s_done: got %b want 1", name, hif.done); else n_pass++;
        @(negedge clk);
        n_checks++;
        if (obs_q.size() != exp_q.size()) $display("FAIL %s_count: got %0d want %0d", name, obs_q.size(), exp_q.size());
        else n_pass++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            wr_t e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++;
            if (o.a !== e.a || o.d !== e.d) $display("FAIL %s_wr: got %h:%0d want %h:%0d", name, o.a, o.d, e.a, e.d);
            else n_pass++;
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        bit saw_done;
        start(32'h13579BDF, 11'h300, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        n_checks++; if (wr_en !== 1'b1) $display("FAIL mid_wr_en_pre: got %b want 1", wr_en); else n_pass++;
        #2 reset_n = 1'b0;
        #1;
        n_checks++; if (wr_en !== 1'b0) $display("FAIL mid_wr_en: got %b want 0", wr_en); else n_pass++;
        n_checks++; if (hif.busy !== 1'b0) $display("FAIL mid_busy: got %b want 0", hif.busy); else n_pass++;
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 1) reset_n = 1'b1;
            if (hif.done === 1'b1) saw_done = 1'b1;
        end
        n_checks++; if (saw_done) $display("FAIL mid_no_done: got 1 want 0"); else n_pass++;
        test_print("after_rst", 32'hDEADBEEF, 11'h200, 1'b0);
    endtask

    task automatic test_back_to_back();
        obs_q.delete();
        push_expected(32'h12345678, 11'h040, 1'b0);
        push_expected(32'h9ABCDEF0, 11'h040, 1'b0);
        start(32'h12345678, 11'h040, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        hif.value = 32'h9ABCDEF0;
        for (int i = 0; i < 40 && hif.done !== 1'b1; i++) @(negedge clk);
        n_checks++; if (hif.done !== 1'b1) $display("FAIL b2b_done1: got %b want 1", hif.done); else n_pass++;
        @(negedge clk);
        n_checks++; if (hif.busy !== 1'b0) $display("FAIL b2b_idle_gap: got %b want 0", hif.busy); else n_pass++;
        @(negedge clk);
        n_checks++; if (hif.busy !== 1'b1) $display("FAIL b2b_restart: got %b want 1", hif.busy); else n_pass++;
        hif.req = 1'b0;
        for (int i = 0; i < 40 && hif.done !== 1'b1; i++) @(negedge clk);
        n_checks++; if (hif.done !== 1'b1) $display("FAIL b2b_done2: got %b want 1", hif.done); else n_pass++;
        @(negedge clk);
        n_checks++;
        if (obs_q.size() != exp_q.size()) $display("FAIL b2b_count: got %0d want %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            wr_t e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++;
            if (o.a !== e.a || o.d !== e.d) $display("FAIL b2b_wr: got %h:%0d want %h:%0d", o.a, o.d, e.a, e.d);
            else n_pass++;
        end
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_print("blank_a5", 32'h000000A5, 11'h000, 1'b1);
        test_print("blank_zero", 32'h00000000, 11'h010, 1'b1);
        test_print("noblank_zero", 32'h00F00000, 11'h020, 1'b0);
        test_print("wrap", 32'h01234567, 11'h7FE, 1'b0);
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
